br_predict: RTL

- Fetch-side branch predictor that consumes the execute-stage branch resolution (`br_taken_c`).
- It contains three structures:
  - a direct-mapped BHT of 2-bit saturating counters;
  - a tagged BTB for predicting next PC in fetch;
  - a mispredict/redirect generator fed by the resolved outcome in execute.
- Sits between the PC register (fetch) and the branch comparator (execute) of the 3-stage pipeline.

---
 rtl/br_predict.sv | 112 +++++++++++
 1 files changed

// File: rtl/br_predict.sv
// Fetch-side branch predictor: 2-bit BHT + tagged BTB, zero-latency prediction from fetch_pc_i.
// Mispredict/redirect registered (1 cycle) from execute resolution; stall_i freezes tables and suppresses the pulse.
module br_predict #(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = 4,
    parameter int TAG_W   = 27
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] fetch_pc_i,
    output logic        pred_taken_o,
    output logic [31:0] pred_target_o,
    input  logic        ex_valid_i,
    input  logic        ex_is_br_i,
    input  logic [31:0] ex_pc_i,
    input  logic        ex_compressed_i,
    input  logic        br_taken_c,
    input  logic [31:0] ex_target_i,
    input  logic        ex_pred_taken_i,
    input  logic [31:0] ex_pred_target_i,
    input  logic        stall_i,
    output logic        mispredict_o,
    output logic [31:0] redirect_pc_o,
    output logic [15:0] mispred_cnt_o
);

    logic [1:0]         ctr        [ENTRIES];
    logic [ENTRIES-1:0] btb_valid;
    logic [TAG_W-1:0]   btb_tag    [ENTRIES];
    logic [31:0]        btb_target [ENTRIES];

    logic [IDX_W-1:0] fetch_idx;
    logic [TAG_W-1:0] fetch_tag;
    logic             fetch_hit;

    assign fetch_idx     = fetch_pc_i[IDX_W:1];
    assign fetch_tag     = fetch_pc_i[31:IDX_W+1];
    assign fetch_hit     = btb_valid[fetch_idx] && (btb_tag[fetch_idx] == fetch_tag);
    assign pred_taken_o  = fetch_hit && ctr[fetch_idx][1];
    assign pred_target_o = pred_taken_o ? btb_target[fetch_idx] : fetch_pc_i + 32'd4;

    logic [IDX_W-1:0] ex_idx;
    logic [TAG_W-1:0] ex_tag;
    logic             ex_hit;
    logic             res;
    logic [31:0]      fallthru;
    logic [31:0]      actual_next;
    logic             wrong;
    logic [1:0]       ctr_cur;
    logic [1:0]       ctr_next;

    assign ex_idx      = ex_pc_i[IDX_W:1];
    assign ex_tag      = ex_pc_i[31:IDX_W+1];
    assign ex_hit      = btb_valid[ex_idx] && (btb_tag[ex_idx] == ex_tag);
    assign res         = ex_valid_i && ex_is_br_i && !stall_i;
    assign fallthru    = ex_pc_i + (ex_compressed_i ? 32'd2 : 32'd4);
    assign actual_next = br_taken_c ? ex_target_i : fallthru;
    assign wrong       = res && (actual_next != ex_pred_target_i);
    assign ctr_cur     = ctr[ex_idx];

    // A taken branch that displaces another entry starts weakly taken rather than inheriting the alias's history.
    always_comb begin
        ctr_next = ctr_cur;
        if (br_taken_c) begin
            if (!ex_hit)
                ctr_next = 2'b10;
            else if (ctr_cur != 2'b11)
                ctr_next = ctr_cur + 2'd1;
        end else if (ctr_cur != 2'b00) begin
            ctr_next = ctr_cur - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++)
                ctr[i] <= 2'b01;
            btb_valid <= '0;
        end else if (res) begin
            ctr[ex_idx] <= ctr_next;
            if (br_taken_c)
                btb_valid[ex_idx] <= 1'b1;
        end
    end

    // Tag/target need no reset: they are qualified by btb_valid.
    always_ff @(posedge clk) begin
        if (res && br_taken_c) begin
            btb_tag[ex_idx]    <= ex_tag;
            btb_target[ex_idx] <= ex_target_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mispredict_o  <= 1'b0;
            redirect_pc_o <= '0;
            mispred_cnt_o <= '0;
        end else begin
            mispredict_o <= wrong;
            if (wrong) begin
                redirect_pc_o <= actual_next;
                if (mispred_cnt_o != 16'hFFFF)
                    mispred_cnt_o <= mispred_cnt_o + 16'd1;
            end
        end
    end

    logic unused_ok;
    assign unused_ok = ex_pred_taken_i;

endmodule
